evg_sequence_player: RTL and testbench
======================================

Name: evg_sequence_player

Overview:
- Timed event scheduler that drives the sequence-event input (highest priority) of the event-generator transmitter core.
- Holds a table of entries, each a delay and an event code. On a trigger, it plays the entries out in order, with cycle-exact spacing in the transmitter clock domain.
- Table is loaded through a simple write port in the same clock domain.
- Status outputs (running, done, overrun) feed the register block.

Parameters:
- ADDR_WIDTH, 10, table depth = 2**ADDR_WIDTH entries
- DELAY_WIDTH, 24, width of per-entry delay field, in evgTxClk cycles
- EVCODE_END, 8'h7F, code that marks end of sequence; this code is never transmitted

Ports:
- evgTxClk  in  1  transmitter clock; the only clock
- evgTxReset  in  1  asynchronous, active-high reset
- evgSeqWrEnable  in  1  table write strobe
- evgSeqWrAddr  in  ADDR_WIDTH  table write address
- evgSeqWrData  in  DELAY_WIDTH+8  {delay, evcode}; evcode in bits [7:0]
- evgSeqTrigger  in  1  single-cycle start pulse
- evgSeqAbort  in  1  single-cycle stop pulse
- evgSequenceEventTDATA  out  8  event code to transmitter core
- evgSequenceEventTVALID  out  1  single-cycle event strobe; no TREADY, because sequence events always win
- evgSeqRunning  out  1  high while playing
- evgSeqDone  out  1  single-cycle pulse at normal completion
- evgSeqOverrun  out  1  single-cycle pulse when a trigger arrives while running
- evgSeqAddress  out  ADDR_WIDTH  index of the entry currently awaited

Behaviour:
- Interface: one clock (evgTxClk); reset is asynchronous and active-high (evgTxReset).
- Reset values: all outputs 0, state IDLE. Table contents are not reset.
- Table: single-port-write / single-port-read synchronous RAM with 1-cycle read latency. Writes are accepted in any state. A write to an entry not yet fetched during play takes effect.
- States:
  - IDLE: read address held at 0.
  - PRIME: one cycle, waits for RAM output of entry 0.
  - WAIT: delay down-counter running.
  - Return to IDLE after completion or abort.
- Trigger in IDLE (cycle T): PRIME at T+1, WAIT entered at T+2 with counter = delay0. evgSeqRunning goes high at T+1.
- WAIT:
  - Counter zero with code != EVCODE_END: TVALID=1 and TDATA=code in the next cycle.
  - In that same counter-zero cycle, the next entry's fetched data loads the counter (read address advances one entry ahead, prefetch).
  - Timing for delay Dk: emit(0) = T+3+D0; emit(k) = emit(k-1)+1+Dk. Delay 0 therefore gives back-to-back events.
- End of sequence, at the cycle the entry would have been emitted. Triggered by either:
  - an entry with code EVCODE_END (no TVALID for it), or
  - the cycle after the entry at address 2**ADDR_WIDTH-1 is emitted (no wrap).
  - Action: evgSeqDone pulses, evgSeqRunning drops, state goes to IDLE.
- evgSeqAddress shows the index of the entry being counted down.
- Abort in any state: IDLE next cycle, running low, no TVALID and no done pulse. Abort wins over a simultaneous trigger.
- Trigger while running: ignored for playback; evgSeqOverrun pulses next cycle.
- Trigger in the same cycle as end-of-sequence: counts as an overrun; no restart.
- Reset mid-play: outputs drop immediately (asynchronous).
- Counter: DELAY_WIDTH bits, decrement only, no wrap, because it reloads at zero.

Optional Feature:
- Macro EVG_SEQ_CYCLIC_EN.
- Defined:
  - Adds input evgSeqCyclic (1 bit).
  - When it is high at end of sequence: evgSeqDone pulses, but the player goes to PRIME at address 0 instead of IDLE. Running stays high.
  - Entry 0 is emitted 3+D0 cycles after the end cycle.
  - Abort still stops playback.
- Undefined: port absent; behaviour as above.

Decomposition:
- Package evg_pkg:
  - EVCODE_END default
  - entry field offsets (EVCODE_LSB=0, DELAY_LSB=8)
  - state enum {IDLE, PRIME, WAIT}
- One sub-module: evg_sequence_ram, a generic inferred RAM with 1-cycle read. The FSM and counter stay in the parent.

Test Plan:
- Load {5,0x01},{0,0x02},{3,0x03},{0,EVCODE_END}; trigger at T -> TVALID with 0x01@T+8, 0x02@T+9, 0x03@T+13; done@T+14; running T+1..T+13.
- Single entry {0,EVCODE_END}; trigger -> no TVALID; done@T+3.
- Same table as test 1; trigger again at T+6 -> overrun pulse @T+7; timing unchanged.
- Abort at T+10 in test 1 -> 0x03 never sent; no done; running low @T+11.
- Trigger and abort together in IDLE -> remains IDLE; no outputs.
- EVG_SEQ_CYCLIC_EN, evgSeqCyclic=1, table {2,0x05},{0,END}; trigger at T -> 0x05@T+5; done@T+6; 0x05@T+11; repeats until abort.

Source files
------------

// File: rtl/evg_pkg.sv
// Shared definitions for the event-generator sequence player: table entry layout,
// default end-of-sequence code and the player state encoding.
package evg_pkg;

    localparam logic [7:0] EVCODE_END_DEFAULT = 8'h7F;

    // Table word layout: {delay, evcode}
    localparam int EVCODE_LSB = 0;
    localparam int DELAY_LSB  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        WAIT  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/evg_sequence_player_if.sv
// Sequence-event stream from the player into the transmitter core.
// There is no TREADY because sequence events always win arbitration.
interface evg_sequence_player_if;
    logic [7:0] evgSequenceEventTDATA;
    logic       evgSequenceEventTVALID;

    modport master (output evgSequenceEventTDATA, output evgSequenceEventTVALID);
    modport slave  (input  evgSequenceEventTDATA, input  evgSequenceEventTVALID);
endinterface

// File: rtl/evg_sequence_ram.sv
// Generic inferred simple dual-port RAM: one write port, one read port,
// registered read (1-cycle latency, read-before-write on address collision).
module evg_sequence_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Contents are deliberately left out of reset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/evg_sequence_player.sv
// Timed sequence-event player: plays {delay, evcode} table entries out with cycle-exact spacing.
// Optional feature macro: EVG_SEQ_CYCLIC_EN adds evgSeqCyclic (restart from entry 0 at end).
module evg_sequence_player
    import evg_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 10,
    parameter int         DELAY_WIDTH = 24,
    parameter logic [7:0] EVCODE_END  = EVCODE_END_DEFAULT
) (
    input  logic                     evgTxClk,
    input  logic                     evgTxReset,
    input  logic                     evgSeqWrEnable,
    input  logic [ADDR_WIDTH-1:0]    evgSeqWrAddr,
    input  logic [DELAY_WIDTH+7:0]   evgSeqWrData,
    input  logic                     evgSeqTrigger,
    input  logic                     evgSeqAbort,
`ifdef EVG_SEQ_CYCLIC_EN
    input  logic                     evgSeqCyclic,
`endif
    evg_sequence_player_if.master    ev_o,
    output logic                     evgSeqRunning,
    output logic                     evgSeqDone,
    output logic                     evgSeqOverrun,
    output logic [ADDR_WIDTH-1:0]    evgSeqAddress
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    seq_state_e              state_q, state_d;
    logic [DELAY_WIDTH-1:0]  cnt_q, cnt_d;
    logic [7:0]              code_q, code_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    restart_q, restart_d;
    logic                    valid_q, valid_d;
    logic [7:0]              data_q, data_d;
    logic                    done_q, done_d;
    logic                    ovr_q, ovr_d;

    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DELAY_WIDTH+7:0]  rd_data;
    logic [DELAY_WIDTH-1:0]  rd_delay;
    logic [7:0]              rd_code;
    logic                    running;
    logic                    cyclic;

`ifdef EVG_SEQ_CYCLIC_EN
    assign cyclic = evgSeqCyclic;
`else
    assign cyclic = 1'b0;
`endif

    evg_sequence_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DELAY_WIDTH + 8)
    ) u_ram (
        .clk     (evgTxClk),
        .wr_en   (evgSeqWrEnable),
        .wr_addr (evgSeqWrAddr),
        .wr_data (evgSeqWrData),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_delay = rd_data[DELAY_LSB +: DELAY_WIDTH];
    assign rd_code  = rd_data[EVCODE_LSB +: 8];
    assign running  = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        addr_d    = addr_q;
        restart_d = 1'b0;
        valid_d   = 1'b0;
        data_d    = '0;
        done_d    = 1'b0;
        ovr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (evgSeqTrigger) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                state_d = WAIT;
                cnt_d   = rd_delay;
                code_d  = rd_code;
                addr_d  = '0;
            end
            WAIT: begin
                if (restart_q) begin
                    // One spare cycle after a cyclic end so entry 0 lands 3+D0 after it
                    state_d = PRIME;
                    addr_d  = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (code_q == EVCODE_END) begin
                    done_d = 1'b1;
                    addr_d = '0;
                    if (cyclic) begin
                        restart_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    valid_d = 1'b1;
                    data_d  = code_q;
                    if (addr_q == ADDR_LAST) begin
                        // No wrap: a synthetic zero-delay end entry closes the table
                        cnt_d  = '0;
                        code_d = EVCODE_END;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        cnt_d  = rd_delay;
                        code_d = rd_code;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (running && evgSeqTrigger) begin
            ovr_d = 1'b1;
        end

        if (evgSeqAbort) begin
            state_d   = IDLE;
            addr_d    = '0;
            restart_d = 1'b0;
            valid_d   = 1'b0;
            data_d    = '0;
            done_d    = 1'b0;
            ovr_d     = 1'b0;
        end

        // Read one entry ahead of the counted one so the reload is ready at counter zero
        rd_addr = (state_d == WAIT) ? addr_d + 1'b1 : '0;
    end

    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            addr_q    <= '0;
            restart_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            addr_q    <= addr_d;
            restart_q <= restart_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    assign ev_o.evgSequenceEventTDATA  = data_q;
    assign ev_o.evgSequenceEventTVALID = valid_q;
    assign evgSeqRunning               = running;
    assign evgSeqDone                  = done_q;
    assign evgSeqOverrun               = ovr_q;
    assign evgSeqAddress               = addr_q;

endmodule

// File: tb/tb_evg_sequence_player.sv
// Self-checking bench for evg_sequence_player: cycle vector table, hand-written corner
// sequences and randomized tables checked against a schedule-level reference model.
module tb_evg_sequence_player;
    import evg_pkg::*;

    localparam int         AW    = 4;
    localparam int         DW    = 8;
    localparam int         N     = 16;
    localparam int         MAXC  = 128;
    localparam logic [7:0] EVEND = 8'h7F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW+7:0] wr_data = '0;
    logic          trig    = 1'b0;
    logic          abort_s = 1'b0;
`ifdef EVG_SEQ_CYCLIC_EN
    logic          cyclic  = 1'b0;
`endif
    logic          running, done, overrun;
    logic [AW-1:0] seq_addr;

    evg_sequence_player_if ev_if ();

    evg_sequence_player #(
        .ADDR_WIDTH  (AW),
        .DELAY_WIDTH (DW),
        .EVCODE_END  (EVEND)
    ) dut (
        .evgTxClk       (clk),
        .evgTxReset     (rst),
        .evgSeqWrEnable (wr_en),
        .evgSeqWrAddr   (wr_addr),
        .evgSeqWrData   (wr_data),
        .evgSeqTrigger  (trig),
        .evgSeqAbort    (abort_s),
`ifdef EVG_SEQ_CYCLIC_EN
        .evgSeqCyclic   (cyclic),
`endif
        .ev_o           (ev_if),
        .evgSeqRunning  (running),
        .evgSeqDone     (done),
        .evgSeqOverrun  (overrun),
        .evgSeqAddress  (seq_addr)
    );

    int vectors     = 0;
    int miscompares = 0;

    bit         exp_valid [MAXC];
    logic [7:0] exp_data  [MAXC];
    bit         exp_done  [MAXC];
    bit         exp_run   [MAXC];
    bit         exp_ovr   [MAXC];

    logic [DW-1:0] mdelay [N];
    logic [7:0]    mcode  [N];

    typedef struct {
        bit            trig;
        bit            valid;
        logic [7:0]    data;
        bit            done;
        bit            run;
        logic [AW-1:0] addr;
    } vec_t;
    vec_t vt [17];

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    task automatic wr_entry(input int a, input logic [DW-1:0] d, input logic [7:0] c);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = {d, c};
        mdelay[a] = d;
        mcode[a]  = c;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic load_test1();
        wr_entry(0, 8'd5, 8'h01);
        wr_entry(1, 8'd0, 8'h02);
        wr_entry(2, 8'd3, 8'h03);
        wr_entry(3, 8'd0, EVEND);
    endtask

    task automatic clear_exp();
        for (int c = 0; c < MAXC; c++) begin
            exp_valid[c] = 1'b0;
            exp_data[c]  = 8'h00;
            exp_done[c]  = 1'b0;
            exp_run[c]   = 1'b0;
            exp_ovr[c]   = 1'b0;
        end
    endtask

    task automatic set_run(input int a, input int b);
        for (int c = a; c <= b; c++) exp_run[c] = 1'b1;
    endtask

    task automatic set_emit(input int c, input logic [7:0] code);
        exp_valid[c] = 1'b1;
        exp_data[c]  = code;
    endtask

    task automatic check_cycle(input int c);
        chk("tvalid", c, ev_if.evgSequenceEventTVALID, exp_valid[c]);
        if (exp_valid[c]) chk("tdata", c, ev_if.evgSequenceEventTDATA, exp_data[c]);
        chk("done", c, done, exp_done[c]);
        chk("running", c, running, exp_run[c]);
        chk("overrun", c, overrun, exp_ovr[c]);
    endtask

    // Trigger always at cycle 0; optional second trigger and abort cycles.
    task automatic run_case(input string name, input int len, input int trig2, input int abort_at);
        int errs0;
        errs0 = miscompares;
        for (int c = 0; c < len; c++) begin
            trig    = (c == 0) || (c == trig2);
            abort_s = (c == abort_at);
            @(negedge clk);
            check_cycle(c);
            @(posedge clk); #1;
        end
        trig    = 1'b0;
        abort_s = 1'b0;
        $display("case %s: cycles=%0d trig2=%0d abort=%0d errors=%0d", name, len, trig2, abort_at,
                 miscompares - errs0);
    endtask

    // Reference model: walks the table as an event schedule, returns the done cycle.
    task automatic model_schedule(output int done_t);
        int t;
        int k;
        clear_exp();
        k = 0;
        t = 3 + int'(mdelay[0]);
        done_t = -1;
        while (done_t < 0) begin
            if (mcode[k] == EVEND) begin
                done_t = t;
            end else begin
                set_emit(t, mcode[k]);
                if (k == N - 1) begin
                    done_t = t + 1;
                end else begin
                    k++;
                    t = t + 1 + int'(mdelay[k]);
                end
            end
        end
        exp_done[done_t] = 1'b1;
        set_run(1, done_t - 1);
    endtask

    task automatic model_ctrl(input int x, input int a);
        if (x >= 0 && exp_run[x] && x != a) exp_ovr[x + 1] = 1'b1;
        if (a >= 0) begin
            for (int c = a + 1; c < MAXC; c++) begin
                exp_valid[c] = 1'b0;
                exp_done[c]  = 1'b0;
                exp_run[c]   = 1'b0;
                exp_ovr[c]   = 1'b0;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 0, ev_if.evgSequenceEventTVALID, 1'b0);
        chk("rst_tdata", 0, ev_if.evgSequenceEventTDATA, 8'h00);
        chk("rst_running", 0, running, 1'b0);
        chk("rst_done", 0, done, 1'b0);
        chk("rst_overrun", 0, overrun, 1'b0);
        chk("rst_addr", 0, seq_addr, 4'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic four-entry sequence as a per-cycle vector table
        for (int c = 0; c < 17; c++)
            vt[c] = '{trig: (c == 0), valid: 1'b0, data: 8'h00, done: 1'b0,
                      run: (c >= 1 && c <= 13), addr: '0};
        vt[8].valid  = 1'b1; vt[8].data  = 8'h01; vt[8].addr  = 4'd1;
        vt[9].valid  = 1'b1; vt[9].data  = 8'h02; vt[9].addr  = 4'd2;
        vt[10].addr  = 4'd2; vt[11].addr = 4'd2;  vt[12].addr = 4'd2;
        vt[13].valid = 1'b1; vt[13].data = 8'h03; vt[13].addr = 4'd3;
        vt[14].done  = 1'b1;

        load_test1();
        for (int c = 0; c < 17; c++) begin
            trig = vt[c].trig;
            @(negedge clk);
            chk("v_tvalid", c, ev_if.evgSequenceEventTVALID, vt[c].valid);
            if (vt[c].valid) chk("v_tdata", c, ev_if.evgSequenceEventTDATA, vt[c].data);
            chk("v_done", c, done, vt[c].done);
            chk("v_running", c, running, vt[c].run);
            chk("v_addr", c, seq_addr, vt[c].addr);
            chk("v_overrun", c, overrun, 1'b0);
            @(posedge clk); #1;
        end
        trig = 1'b0;
        $display("case vectors: 17 cycles applied");

        // Retrigger while running: overrun pulse, timing unchanged
        clear_exp();
        set_emit(8, 8'h01); set_emit(9, 8'h02); set_emit(13, 8'h03);
        exp_done[14] = 1'b1; set_run(1, 13); exp_ovr[7] = 1'b1;
        run_case("overrun", 17, 6, -1);

        // Abort mid-play
        clear_exp();
        set_emit(8, 8'h01); set_emit(9, 8'h02); set_run(1, 10);
        run_case("abort", 17, -1, 10);

        // Trigger and abort together in IDLE
        clear_exp();
        run_case("trig_abort", 6, -1, 0);

        // Asynchronous reset mid-play
        trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("pre_rst_tvalid", 8, ev_if.evgSequenceEventTVALID, 1'b1);
        chk("pre_rst_running", 8, running, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_tvalid", 8, ev_if.evgSequenceEventTVALID, 1'b0);
        chk("async_rst_running", 8, running, 1'b0);
        chk("async_rst_addr", 8, seq_addr, 4'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("case async_reset: done");

        // Single end entry
        wr_entry(0, 8'd0, EVEND);
        clear_exp();
        exp_done[3] = 1'b1; set_run(1, 2);
        run_case("single_end", 6, -1, -1);

        // Full table without end code: ends after the last address
        for (int i = 0; i < N; i++) wr_entry(i, 8'd0, 8'h10 + 8'(i));
        clear_exp();
        for (int i = 0; i < N; i++) set_emit(3 + i, 8'h10 + 8'(i));
        exp_done[19] = 1'b1; set_run(1, 18);
        run_case("last_addr", 22, -1, -1);

`ifdef EVG_SEQ_CYCLIC_EN
        wr_entry(0, 8'd2, 8'h05);
        wr_entry(1, 8'd0, EVEND);
        cyclic = 1'b1;
        clear_exp();
        set_emit(5, 8'h05); set_emit(11, 8'h05); set_emit(17, 8'h05);
        exp_done[6] = 1'b1; exp_done[12] = 1'b1; exp_done[18] = 1'b1;
        set_run(1, 22);
        run_case("cyclic", 26, -1, 22);
        cyclic = 1'b0;
`endif

        // Randomized tables against the schedule model
        for (int it = 0; it < 25; it++) begin
            int end_pos;
            int done_t;
            int x;
            int a;
            logic [7:0] cd;
            end_pos = $urandom_range(0, N);
            for (int i = 0; i < N; i++) begin
                cd = 8'($urandom_range(0, 254));
                if (cd == EVEND) cd = 8'h00;
                if (i == end_pos) cd = EVEND;
                wr_entry(i, 8'($urandom_range(0, 3)), cd);
            end
            model_schedule(done_t);
            x = ($urandom_range(0, 1) == 1) ? $urandom_range(1, done_t - 1) : -1;
            a = ($urandom_range(0, 2) == 0) ? $urandom_range((x >= 0) ? x + 1 : 0, done_t) : -1;
            model_ctrl(x, a);
            run_case($sformatf("random%0d", it), ((a >= 0) ? a : done_t) + 4, x, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
